// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_state_e : fetch FSM encoding
//   fetch_entry_t : default {pc, instr} buffer entry (4-bit PC, 32-bit word)
//   sat_inc16     : saturating 16-bit increment for the performance counters
package if_pkg;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] HALT_WORD   = 32'h0;

  localparam int IF_ADDR_W = 4;
  localparam int IF_DATA_W = 32;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_FULL  = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [IF_ADDR_W-1:0] pc;
    logic [IF_DATA_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries.
//   clk, rst_n : clock, async active-low reset (contents cleared too)
//   push, din  : write din at the tail (ignored when full unless popping)
//   pop        : drop the head (ignored when empty)
//   flush      : empty the FIFO; overrides push and pop
//   full, empty, count : occupancy
//   head       : entry at the head, valid when !empty
module fetch_fifo
  import if_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = 2,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  entry_t           din,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output entry_t           head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               do_push;
  logic               do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: walks the combinational program ROM, buffers
// {pc, instr} words in a small FIFO and hands them to decode over a
// valid/ready handshake. Supports redirect with flush and stops on HALT_WORD.
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   rom_addr_out        : ROM byte address (current pc)
//   rom_data_in         : ROM word, valid in the same cycle
//   if_valid/if_ready   : decode handshake on the FIFO head
//   if_pc, if_instr     : head entry; hold last shown value while empty
//   redirect_valid/_pc  : one-cycle branch/jump request (wins over push/pop)
//   halted              : fetch stopped on HALT_WORD
//   misalign_err        : one-cycle pulse after a redirect with pc[1:0] != 0
//   fetch_count         : pushes (saturating), FETCH_PERF_EN only, else 0
//   stall_count         : S_FULL cycles without pop, FETCH_PERF_EN only, else 0
//
// Build option: define FETCH_PERF_EN to include the two perf counters.
//
// state   | meaning
// --------+--------------------------------------------
// S_FETCH | fetching one word per cycle while room
// S_FULL  | FIFO full, waiting for decode to pop
// S_HALT  | HALT_WORD fetched, waiting for redirect
module instr_fetch_unit
  import if_pkg::*;
#(
  parameter int                ADDR_W     = 4,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr_out,
  input  logic [DATA_W-1:0] rom_data_in,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic              misalign_err,
  output logic [15:0]       fetch_count,
  output logic [15:0]       stall_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              misalign_q;
  entry_t            last_q;

  logic              push, pop, flush;
  logic              full, empty;
  logic [CNT_W-1:0]  count;
  entry_t            head;
  entry_t            din;
  logic              pop_req;
  logic              can_push;
  logic              is_halt_word;

  assign din          = '{pc: pc_q, instr: rom_data_in};
  assign pop_req      = !empty && if_ready;
  assign is_halt_word = (rom_data_in == DATA_W'(HALT_WORD));

  // A pop frees a slot in the same edge, so a full FIFO can still accept.
  assign can_push = ((state_q == S_FETCH) && (!full || pop_req)) ||
                    ((state_q == S_FULL) && pop_req);

  fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
      state_d = S_FETCH;
    end else begin
      pop = pop_req;
      if (can_push) begin
        push = 1'b1;
        if (is_halt_word) begin
          // The halt word still goes to decode; pc stays on it.
          state_d = S_HALT;
        end else begin
          pc_d = pc_q + ADDR_W'(INSTR_BYTES);
          if (!pop_req && (count == CNT_W'(FIFO_DEPTH - 1))) begin
            state_d = S_FULL;
          end else begin
            state_d = S_FETCH;
          end
        end
      end else if ((state_q == S_FETCH) && full && !pop_req) begin
        state_d = S_FULL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      // Remember what was shown so an empty FIFO keeps presenting it.
      last_q     <= '{pc: if_pc, instr: if_instr};
    end
  end

  assign rom_addr_out = pc_q;
  assign if_valid     = !empty;
  assign if_pc        = empty ? last_q.pc    : head.pc;
  assign if_instr     = empty ? last_q.instr : head.instr;
  assign halted       = (state_q == S_HALT);
  assign misalign_err = misalign_q;

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push) begin
        fetch_cnt_q <= sat_inc16(fetch_cnt_q);
      end
      if ((state_q == S_FULL) && !pop) begin
        stall_cnt_q <= sat_inc16(stall_cnt_q);
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign fetch_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] W0 = 32'h44216a93;
  localparam logic [31:0] W4 = 32'h65125748;
  localparam logic [31:0] W8 = 32'hffb00193;
  localparam logic [31:0] WC = 32'h156778dc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rom_addr_out;
  logic [31:0] rom_data_in;
  logic        if_valid;
  logic        if_ready;
  logic [3:0]  if_pc;
  logic [31:0] if_instr;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;
  logic        halted;
  logic        misalign_err;
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
  logic        rom_stub;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr_out   (rom_addr_out),
    .rom_data_in    (rom_data_in),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
  );

  // Production ROM, optionally stubbed to return zero at 0x8.
  always_comb begin
    case (rom_addr_out)
      4'h0:    rom_data_in = W0;
      4'h4:    rom_data_in = W4;
      4'h8:    rom_data_in = rom_stub ? 32'h0 : W8;
      4'hC:    rom_data_in = WC;
      default: rom_data_in = 32'h0;
    endcase
  end

  typedef struct {
    bit          rs;
    bit          stub;
    bit          rdy;
    bit          rv;
    logic [3:0]  rpc;
    bit          ev;
    logic [3:0]  epc;
    logic [31:0] ein;
    bit          eh;
    bit          em;
    logic [3:0]  ea;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit rs, bit stub, bit rdy, bit rv, logic [3:0] rpc,
                              bit ev, logic [3:0] epc, logic [31:0] ein,
                              bit eh, bit em, logic [3:0] ea);
    vec_t v;
    v.rs = rs; v.stub = stub; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.ein = ein; v.eh = eh; v.em = em; v.ea = ea;
    return v;
  endfunction

  task automatic check(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 4'h0;
    rom_stub       = 1'b0;

    // Sequential read with wrap.
    vq.push_back(mk(1,0,1,0,4'h0, 0,4'h0,32'h0, 0,0,4'h0));
    vq.push_back(mk(0,0,1,0,4'h0, 1,4'h0,W0,    0,0,4'h4));
    vq.push_back(mk(0,0,1,0,4'h0, 1,4'h4,W4,    0,0,4'h8));
    vq.push_back(mk(0,0,1,0,4'h0, 1,4'h8,W8,    0,0,4'hC));
    vq.push_back(mk(0,0,1,0,4'h0, 1,4'hC,WC,    0,0,4'h0));
    vq.push_back(mk(0,0,1,0,4'h0, 1,4'h0,W0,    0,0,4'h4));
    // Decode stall fills the FIFO, then drains without gap or duplicate.
    vq.push_back(mk(1,0,0,0,4'h0, 0,4'h0,32'h0, 0,0,4'h0));
    vq.push_back(mk(0,0,0,0,4'h0, 1,4'h0,W0,    0,0,4'h4));
    vq.push_back(mk(0,0,0,0,4'h0, 1,4'h0,W0,    0,0,4'h8));
    vq.push_back(mk(0,0,0,0,4'h0, 1,4'h0,W0,    0,0,4'h8));
    vq.push_back(mk(0,0,0,0,4'h0, 1,4'h0,W0,    0,0,4'h8));
    vq.push_back(mk(0,0,1,0,4'h0, 1,4'h0,W0,    0,0,4'h8));
    vq.push_back(mk(0,0,1,0,4'h0, 1,4'h4,W4,    0,0,4'hC));
    vq.push_back(mk(0,0,1,0,4'h0, 1,4'h8,W8,    0,0,4'h0));
    // Redirect to 0xC with two buffered entries flushes them.
    vq.push_back(mk(1,0,0,0,4'h0, 0,4'h0,32'h0, 0,0,4'h0));
    vq.push_back(mk(0,0,0,0,4'h0, 1,4'h0,W0,    0,0,4'h4));
    vq.push_back(mk(0,0,0,0,4'h0, 1,4'h0,W0,    0,0,4'h8));
    vq.push_back(mk(0,0,1,1,4'hC, 1,4'h0,W0,    0,0,4'h8));
    vq.push_back(mk(0,0,1,0,4'h0, 0,4'h0,W0,    0,0,4'hC));
    vq.push_back(mk(0,0,1,0,4'h0, 1,4'hC,WC,    0,0,4'h0));
    // Halt on zero word at 0x8, then redirect to 0x0 resumes.
    vq.push_back(mk(1,1,1,0,4'h0, 0,4'h0,32'h0, 0,0,4'h0));
    vq.push_back(mk(0,1,1,0,4'h0, 1,4'h0,W0,    0,0,4'h4));
    vq.push_back(mk(0,1,1,0,4'h0, 1,4'h4,W4,    0,0,4'h8));
    vq.push_back(mk(0,1,1,0,4'h0, 1,4'h8,32'h0, 1,0,4'h8));
    vq.push_back(mk(0,1,1,0,4'h0, 0,4'h8,32'h0, 1,0,4'h8));
    vq.push_back(mk(0,1,1,1,4'h0, 0,4'h8,32'h0, 1,0,4'h8));
    vq.push_back(mk(0,1,1,0,4'h0, 0,4'h8,32'h0, 0,0,4'h0));
    vq.push_back(mk(0,1,1,0,4'h0, 1,4'h0,W0,    0,0,4'h4));
    // Misaligned redirect to 0x6 pulses the error and fetches from 0x4.
    vq.push_back(mk(1,0,1,0,4'h0, 0,4'h0,32'h0, 0,0,4'h0));
    vq.push_back(mk(0,0,1,1,4'h6, 1,4'h0,W0,    0,0,4'h4));
    vq.push_back(mk(0,0,1,0,4'h0, 0,4'h0,W0,    0,1,4'h4));
    vq.push_back(mk(0,0,1,0,4'h0, 1,4'h4,W4,    0,0,4'h8));

    // Reset state while rst_n is held low.
    #3;
    check("rst_valid",    0, {31'b0, if_valid},     32'h0);
    check("rst_pc",       0, {28'b0, if_pc},        32'h0);
    check("rst_instr",    0, if_instr,              32'h0);
    check("rst_halted",   0, {31'b0, halted},       32'h0);
    check("rst_misalign", 0, {31'b0, misalign_err}, 32'h0);
    check("rst_addr",     0, {28'b0, rom_addr_out}, 32'h0);
    check("rst_fcnt",     0, {16'b0, fetch_count},  32'h0);
    check("rst_scnt",     0, {16'b0, stall_count},  32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      if (vq[i].rs) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      rom_stub       = vq[i].stub;
      if_ready       = vq[i].rdy;
      redirect_valid = vq[i].rv;
      redirect_pc    = vq[i].rpc;
      #2;
      check("valid",    i, {31'b0, if_valid},     {31'b0, vq[i].ev});
      check("pc",       i, {28'b0, if_pc},        {28'b0, vq[i].epc});
      check("instr",    i, if_instr,              vq[i].ein);
      check("halted",   i, {31'b0, halted},       {31'b0, vq[i].eh});
      check("misalign", i, {31'b0, misalign_err}, {31'b0, vq[i].em});
      check("addr",     i, {28'b0, rom_addr_out}, {28'b0, vq[i].ea});
    end

    // Perf counters: 5 cycles with decode stalled (2 pushes, then 3 full
    // cycles), then 10 pop cycles each refilling one slot.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    rst_n          = 1'b1;
    rom_stub       = 1'b0;
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (c == 5) if_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    if_ready = 1'b0;
    #2;
`ifdef FETCH_PERF_EN
    check("perf_fetch", 0, {16'b0, fetch_count}, 32'd12);
    check("perf_stall", 0, {16'b0, stall_count}, 32'd3);
`else
    check("perf_fetch", 0, {16'b0, fetch_count}, 32'd0);
    check("perf_stall", 0, {16'b0, stall_count}, 32'd0);
`endif
    check("perf_valid", 0, {31'b0, if_valid}, 32'h1);

    // Asynchronous reset mid-operation clears everything at once.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 0, {31'b0, if_valid},     32'h0);
    check("arst_pc",    0, {28'b0, if_pc},        32'h0);
    check("arst_instr", 0, if_instr,              32'h0);
    check("arst_addr",  0, {28'b0, rom_addr_out}, 32'h0);
    check("arst_fcnt",  0, {16'b0, fetch_count},  32'h0);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
